// File: rtl/posit_pkg.sv
// Shared posit decode definitions: regime width helper, special encodings and
// the decoded-field record for the default 16-bit, ES=3 configuration.
package posit_pkg;

  function automatic int regime_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int DEFAULT_N     = 16;
  localparam int DEFAULT_ES    = 3;
  localparam int DEFAULT_REG_W = regime_width(DEFAULT_N);

  localparam logic [DEFAULT_N-1:0] POSIT_NAR  = {1'b1, {(DEFAULT_N-1){1'b0}}};
  localparam logic [DEFAULT_N-1:0] POSIT_ZERO = '0;

  typedef struct packed {
    logic                            sign;
    logic signed [DEFAULT_REG_W-1:0] regime;
    logic [DEFAULT_ES-1:0]           exp;
    logic [DEFAULT_N-1:0]            frac;
    logic                            is_zero;
    logic                            is_nar;
  } posit_fields_t;

endpackage

// File: rtl/posit_run_count.sv
// Counts how many bits, starting at the MSB of i_bits, share the MSB's value.
module posit_run_count #(
  parameter  int N  = 16,
  localparam int CW = $clog2(N)
) (
  input  logic [N-2:0]  i_bits,
  output logic [CW-1:0] o_count
);

  logic w_done;

  // The MSB always counts; stop at the first bit that differs from it.
  always_comb begin
    o_count = CW'(1);
    w_done  = 1'b0;
    for (int i = N - 3; i >= 0; i--) begin
      if (!w_done && (i_bits[i] == i_bits[N-2])) begin
        o_count = o_count + CW'(1);
      end else begin
        w_done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_unpack_pipe.sv
// Two-stage pipelined posit decoder with valid/ready on both sides.
// Define POSIT_UNPACK_SCALE_EN to add the registered 'scale' output (k*2^ES + exp).
module posit_unpack_pipe
  import posit_pkg::*;
#(
  parameter  int N     = 16,
  parameter  int ES    = 3,
  localparam int REG_W = regime_width(N),
  localparam int EXP_W = (ES > 0) ? ES : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign,
  output logic signed [REG_W-1:0] regime,
  output logic [EXP_W-1:0]        exp,
  output logic [N-1:0]            frac,
  output logic                    is_zero,
  output logic                    is_nar
`ifdef POSIT_UNPACK_SCALE_EN
  , output logic signed [REG_W+ES-1:0] scale
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] NAR_PAT = {1'b1, {(N-1){1'b0}}};

  logic                    r_s1_valid, r_s1_sign, r_s1_zero, r_s1_nar;
  logic [N-2:0]            r_s1_mag;
  logic [CW-1:0]           r_s1_run;
  logic                    r_s2_valid, r_sign, r_zero, r_nar;
  logic signed [REG_W-1:0] r_regime;
  logic [EXP_W-1:0]        r_exp;
  logic [N-1:0]            r_frac;

  logic                    w_s2_adv, w_accept, w_s2_load, w_special;
  logic [N-2:0]            w_mag;
  logic [CW-1:0]           w_run, w_shamt;
  logic                    w_term;
  logic signed [REG_W-1:0] w_run_s, w_k;
  logic [N+ES-1:0]         w_shifted;
  logic [EXP_W-1:0]        w_exp;

  assign w_s2_adv  = !r_s2_valid | out_ready;
  assign in_ready  = !r_s1_valid | w_s2_adv;
  assign w_accept  = in_valid & in_ready;
  assign w_s2_load = r_s1_valid & w_s2_adv;

  // Low bits of a two's-complement negation depend only on the low bits.
  assign w_mag = in_data[N-1] ? -in_data[N-2:0] : in_data[N-2:0];

  posit_run_count #(.N(N)) u_run_count (
    .i_bits  (w_mag),
    .o_count (w_run)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_run   <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_nar   <= 1'b0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_sign <= in_data[N-1];
        r_s1_mag  <= w_mag;
        r_s1_run  <= w_run;
        r_s1_zero <= (in_data == '0);
        r_s1_nar  <= (in_data == NAR_PAT);
      end
    end
  end

  // A run that fills the whole body has no terminator bit to skip.
  assign w_term    = (r_s1_run != CW'(N - 1));
  assign w_shamt   = r_s1_run + {{(CW-1){1'b0}}, w_term};
  assign w_run_s   = $signed({1'b0, r_s1_run});
  assign w_k       = r_s1_mag[N-2] ? (w_run_s - REG_W'(1)) : -w_run_s;
  assign w_shifted = {r_s1_mag, {(ES+1){1'b0}}} << w_shamt;
  assign w_special = r_s1_zero | r_s1_nar;

  if (ES > 0) begin : g_exp
    assign w_exp = w_shifted[N+ES-1:N];
  end else begin : g_no_exp
    assign w_exp = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_sign     <= 1'b0;
      r_regime   <= '0;
      r_exp      <= '0;
      r_frac     <= '0;
      r_zero     <= 1'b0;
      r_nar      <= 1'b0;
    end else begin
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_load) begin
        r_sign   <= r_s1_sign;
        r_regime <= w_special ? '0 : w_k;
        r_exp    <= w_special ? '0 : w_exp;
        r_frac   <= w_special ? '0 : w_shifted[N-1:0];
        r_zero   <= r_s1_zero;
        r_nar    <= r_s1_nar;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign sign      = r_sign;
  assign regime    = r_regime;
  assign exp       = r_exp;
  assign frac      = r_frac;
  assign is_zero   = r_zero;
  assign is_nar    = r_nar;

`ifdef POSIT_UNPACK_SCALE_EN
  logic signed [REG_W+ES-1:0] w_scale, r_scale;

  // The exponent fills the low ES bits left empty by k*2^ES.
  if (ES > 0) begin : g_scale_exp
    assign w_scale = {w_k, w_exp};
  end else begin : g_scale_k
    assign w_scale = w_k;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scale <= '0;
    end else if (w_s2_load) begin
      r_scale <= w_special ? '0 : w_scale;
    end
  end

  assign scale = r_scale;
`endif

endmodule

// File: tb/tb_posit_unpack_pipe.sv
// Scoreboarded bench for posit_unpack_pipe (N=16, ES=3): directed vectors,
// latency, backpressure, mid-flight reset and a random stream.
module tb_posit_unpack_pipe;
  import posit_pkg::*;

  localparam int N     = DEFAULT_N;
  localparam int ES    = DEFAULT_ES;
  localparam int REG_W = DEFAULT_REG_W;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [N-1:0]            in_data;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    sign;
  logic signed [REG_W-1:0] regime;
  logic [ES-1:0]           exp;
  logic [N-1:0]            frac;
  logic                    is_zero;
  logic                    is_nar;
`ifdef POSIT_UNPACK_SCALE_EN
  logic signed [REG_W+ES-1:0] scale;
`endif

  int checks = 0;
  int failures = 0;
  posit_fields_t expQ[$];
  posit_fields_t monExp;
  posit_fields_t headExp;
  logic [N-1:0] bpData[4];
  int waitN;

  always #5 clk = ~clk;

  posit_unpack_pipe #(.N(N), .ES(ES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .regime    (regime),
    .exp       (exp),
    .frac      (frac),
    .is_zero   (is_zero),
    .is_nar    (is_nar)
`ifdef POSIT_UNPACK_SCALE_EN
    , .scale   (scale)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Bit-serial reference decode: walk the magnitude from the top, field by field.
  function automatic posit_fields_t model(input logic [N-1:0] d);
    posit_fields_t f;
    logic [N-1:0] mag;
    int idx;
    int run;
    logic first;
    f = '0;
    f.sign = d[N-1];
    if (d == POSIT_ZERO) begin
      f.is_zero = 1'b1;
    end else if (d == POSIT_NAR) begin
      f.is_nar = 1'b1;
    end else begin
      mag = d[N-1] ? (~d + 16'd1) : d;
      idx = N - 2;
      first = mag[idx];
      run = 0;
      while (idx >= 0 && mag[idx] == first) begin
        run++;
        idx--;
      end
      f.regime = first ? REG_W'(run - 1) : REG_W'(-run);
      if (idx >= 0) idx--;
      for (int b = ES - 1; b >= 0; b--) begin
        if (idx >= 0) begin
          f.exp[b] = mag[idx];
          idx--;
        end
      end
      for (int b = N - 1; b >= 0; b--) begin
        if (idx >= 0) begin
          f.frac[b] = mag[idx];
          idx--;
        end
      end
    end
    return f;
  endfunction

  function automatic logic [7:0] modelScale(input posit_fields_t f);
    int s;
    s = int'(f.regime) * (1 << ES) + int'(f.exp);
    return s[7:0];
  endfunction

  function automatic posit_fields_t getObserved();
    posit_fields_t f;
    f.sign    = sign;
    f.regime  = regime;
    f.exp     = exp;
    f.frac    = frac;
    f.is_zero = is_zero;
    f.is_nar  = is_nar;
    return f;
  endfunction

  // Drive one item, wait (bounded) for acceptance, and leave in_valid high.
  task automatic applyStimulus(input logic [N-1:0] d);
    int waitCycles;
    waitCycles = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("accept_timeout", {63'b0, in_ready}, 64'd1);
    expQ.push_back(model(d));
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic sendSingle(input logic [N-1:0] d);
    applyStimulus(d);
    idleIn();
    checkOutput("latency_one", {63'b0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_two", {63'b0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", {63'b0, out_valid}, 64'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("result", 64'(getObserved()), 64'(monExp));
`ifdef POSIT_UNPACK_SCALE_EN
        checkOutput("scale", {56'b0, scale}, {56'b0, modelScale(monExp)});
`endif
      end
    end
  end

  initial begin
    in_data = 'x;
    #3;
    checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("reset_fields", 64'(getObserved()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", {63'b0, in_ready}, 64'd1);

    sendSingle(16'b0111001110110101);
    sendSingle(16'b0000000000000011);
    sendSingle(16'b0111111111111111);
    sendSingle(16'h0000);
    sendSingle(16'h8000);
    sendSingle(16'hFFFF);
    sendSingle(16'h0001);
    sendSingle(16'hC3A7);
    drain();

    // Backpressure: four back-to-back items with the consumer stalled at first.
    bpData[0] = 16'h4A21;
    bpData[1] = 16'hB00F;
    bpData[2] = 16'h0123;
    bpData[3] = 16'h7FF0;
    headExp = model(bpData[0]);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(bpData[i]);
        idleIn();
      end
      begin
        waitN = 0;
        @(negedge clk);
        while (!out_valid && waitN < 20) begin
          @(negedge clk);
          waitN++;
        end
        checkOutput("bp_first_valid", {63'b0, out_valid}, 64'd1);
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          checkOutput("bp_hold_data", 64'(getObserved()), 64'(headExp));
          checkOutput("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two items in flight discards both.
    applyStimulus(16'h1234);
    applyStimulus(16'h5678);
    idleIn();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("midrst_fields", 64'(getObserved()), 64'd0);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checkOutput("postrst_no_stale", {63'b0, out_valid}, 64'd0);
      checkOutput("postrst_ready", {63'b0, in_ready}, 64'd1);
    end
    sendSingle(16'b0111001110110101);
    drain();

    for (int i = 0; i < 24; i++) begin
      applyStimulus(16'($urandom()));
      if ($urandom_range(0, 2) == 0) begin
        idleIn();
        @(posedge clk);
        #1;
      end
    end
    idleIn();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
